// File: rtl/year_pkg.sv
// Shared constants and BCD helper functions for the year counter.
package year_pkg;

   localparam int BCD_W = 4;

   function automatic logic is_bcd_digit(input logic [BCD_W-1:0] d);
      return (d <= 4'd9);
   endfunction

   // 2-digit BCD divisible by 4: tens even with units 0/4/8, or tens odd with units 2/6.
   function automatic logic bcd_div4(input logic [7:0] v);
      logic [3:0] units;
      units = v[3:0];
      if (v[4] == 1'b0) return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
      else              return (units == 4'd2) || (units == 4'd6);
   endfunction

   // Operands are zero-extended packed BCD; unsigned compare is MSD first.
   function automatic logic bcd_in_range(input logic [31:0] val,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/bcd_year_counter_digit.sv
// One BCD digit register with ripple carry/borrow; a load overrides counting.
import year_pkg::*;

module bcd_digit_updown (
   input  logic             clk,
   input  logic             rst,
   input  logic [BCD_W-1:0] rst_val,
   input  logic             ld,
   input  logic [BCD_W-1:0] ld_val,
   input  logic             inc,
   input  logic             dec,
   input  logic             cin,
   input  logic             bin,
   output logic             cout,
   output logic             bout,
   output logic [BCD_W-1:0] q
);

   logic [BCD_W-1:0] digit_d, digit_q;

   always_comb begin
      digit_d = digit_q;
      cout    = inc && cin && (digit_q == 4'd9);
      bout    = dec && bin && (digit_q == 4'd0);
      if (ld)
         digit_d = ld_val;
      else if (inc && cin)
         digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
      else if (dec && bin)
         digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) digit_q <= rst_val;
      else     digit_q <= digit_d;
   end

   assign q = digit_q;

endmodule

// File: rtl/bcd_year_counter.sv
// N-digit BCD year counter with MIN/MAX wrap, validated load and Gregorian leap flag.
import year_pkg::*;

module bcd_year_counter #(
   parameter int                      NUM_DIGITS = 4,
   parameter logic [4*NUM_DIGITS-1:0] MIN_YEAR   = 16'h1900,
   parameter logic [4*NUM_DIGITS-1:0] MAX_YEAR   = 16'h2099,
   parameter logic [4*NUM_DIGITS-1:0] RESET_YEAR = 16'h2000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en_yr,
   input  logic                      up,
   input  logic                      down,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   load_val,
   output logic [4*NUM_DIGITS-1:0]   year_bcd,
   output logic                      leap_year,
   output logic                      wrap,
   output logic                      load_err
);

   localparam int W = BCD_W * NUM_DIGITS;

   logic          inc_req, dec_req, at_max, at_min;
   logic          load_ok, all_bcd;
   logic          dig_inc, dig_dec, dig_ld;
   logic [W-1:0]  dig_ld_val;
   logic          wrap_d, wrap_q, load_err_d, load_err_q;
   logic [NUM_DIGITS:0] cy, bw;
   logic [7:0]    yr_t, yr_h;

   always_comb begin
      all_bcd = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (!is_bcd_digit(load_val[i*BCD_W +: BCD_W])) all_bcd = 1'b0;
   end

   assign load_ok = all_bcd && bcd_in_range(32'(load_val), 32'(MIN_YEAR), 32'(MAX_YEAR));

   // load > en_yr > manual adjust; up+down together cancel.
   assign inc_req = !load && (en_yr || (up && !down));
   assign dec_req = !load && !en_yr && down && !up;
   assign at_max  = (year_bcd == MAX_YEAR);
   assign at_min  = (year_bcd == MIN_YEAR);

   always_comb begin
      wrap_d     = (inc_req && at_max) || (dec_req && at_min);
      load_err_d = load && !load_ok;
      dig_inc    = inc_req && !at_max;
      dig_dec    = dec_req && !at_min;
      dig_ld     = (load && load_ok) || wrap_d;
      dig_ld_val = load_val;
      if (!load) dig_ld_val = at_max && inc_req ? MIN_YEAR : MAX_YEAR;
   end

   assign cy[0] = 1'b1;
   assign bw[0] = 1'b1;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_updown u_digit (
         .clk     (clk),
         .rst     (rst),
         .rst_val (RESET_YEAR[g*BCD_W +: BCD_W]),
         .ld      (dig_ld),
         .ld_val  (dig_ld_val[g*BCD_W +: BCD_W]),
         .inc     (dig_inc),
         .dec     (dig_dec),
         .cin     (cy[g]),
         .bin     (bw[g]),
         .cout    (cy[g+1]),
         .bout    (bw[g+1]),
         .q       (year_bcd[g*BCD_W +: BCD_W])
      );
   end

   // The top carry/borrow cannot fire: the range ends are handled by the wrap load.
   logic unused_chain_end;
   assign unused_chain_end = cy[NUM_DIGITS] | bw[NUM_DIGITS];

   always_ff @(posedge clk) begin
      if (rst) begin
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign wrap     = wrap_q;
   assign load_err = load_err_q;

   assign yr_t = year_bcd[7:0];
   if (NUM_DIGITS >= 4) begin : g_h4
      assign yr_h = year_bcd[15:8];
   end else if (NUM_DIGITS == 3) begin : g_h3
      assign yr_h = {4'h0, year_bcd[11:8]};
   end else begin : g_h2
      assign yr_h = 8'h00;
   end

   assign leap_year = (yr_t == 8'h00) ? bcd_div4(yr_h) : bcd_div4(yr_t);

endmodule

// File: tb/tb_bcd_year_counter.sv
// Directed vector table plus a Gregorian leap sweep on a full-range instance.
module tb_bcd_year_counter;

   typedef struct {
      logic        rst;
      logic        load;
      logic        en;
      logic        up;
      logic        down;
      logic [15:0] val;
      logic [15:0] exp_year;
      logic        exp_leap;
      logic        exp_wrap;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en_yr, up, down, load;
   logic [15:0] load_val, year_bcd;
   logic        leap_year, wrap, load_err;

   logic        en_b, load_b;
   logic [15:0] val_b, year_b;
   logic        leap_b, wrap_b, err_b;
   logic        zero_b = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   bcd_year_counter dut (
      .clk(clk), .rst(rst), .en_yr(en_yr), .up(up), .down(down),
      .load(load), .load_val(load_val), .year_bcd(year_bcd),
      .leap_year(leap_year), .wrap(wrap), .load_err(load_err)
   );

   bcd_year_counter #(.NUM_DIGITS(4), .MIN_YEAR(16'h0000), .MAX_YEAR(16'h9999),
                      .RESET_YEAR(16'h2000)) dut_full (
      .clk(clk), .rst(rst), .en_yr(en_b), .up(zero_b), .down(zero_b),
      .load(load_b), .load_val(val_b), .year_bcd(year_b),
      .leap_year(leap_b), .wrap(wrap_b), .load_err(err_b)
   );

   function automatic logic [15:0] to_bcd(input int y);
      return {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
   endfunction

   function automatic logic greg_leap(input int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   vec_t vecs[$];

   function automatic void v(input logic r, input logic ld, input logic e,
                             input logic u, input logic d, input logic [15:0] val,
                             input logic [15:0] ey, input logic el,
                             input logic ew, input logic ee);
      vec_t t;
      t.rst = r; t.load = ld; t.en = e; t.up = u; t.down = d; t.val = val;
      t.exp_year = ey; t.exp_leap = el; t.exp_wrap = ew; t.exp_err = ee;
      vecs.push_back(t);
   endfunction

   initial begin
      //   rst ld en up dn val       year     leap wrap err
      v(1, 0, 0, 0, 0, 16'h0000, 16'h2000, 1, 0, 0);
      v(1, 0, 0, 0, 0, 16'h0000, 16'h2000, 1, 0, 0);
      v(0, 0, 0, 0, 0, 16'h0000, 16'h2000, 1, 0, 0);
      v(0, 1, 0, 0, 0, 16'h1999, 16'h1999, 0, 0, 0);
      v(0, 0, 1, 0, 0, 16'h0000, 16'h2000, 1, 0, 0);
      v(0, 0, 0, 0, 1, 16'h0000, 16'h1999, 0, 0, 0);
      v(0, 1, 0, 0, 0, 16'h2099, 16'h2099, 0, 0, 0);
      v(0, 0, 1, 0, 0, 16'h0000, 16'h1900, 0, 1, 0);
      v(0, 0, 0, 0, 0, 16'h0000, 16'h1900, 0, 0, 0);
      v(0, 0, 0, 0, 1, 16'h0000, 16'h2099, 0, 1, 0);
      v(0, 0, 0, 0, 0, 16'h0000, 16'h2099, 0, 0, 0);
      v(0, 1, 0, 0, 0, 16'h20A5, 16'h2099, 0, 0, 1);
      v(0, 0, 0, 0, 0, 16'h0000, 16'h2099, 0, 0, 0);
      v(0, 1, 0, 0, 0, 16'h2150, 16'h2099, 0, 0, 1);
      v(0, 1, 1, 0, 0, 16'h2024, 16'h2024, 1, 0, 0);
      v(0, 0, 0, 1, 1, 16'h0000, 16'h2024, 1, 0, 0);
      v(0, 1, 0, 0, 0, 16'h2023, 16'h2023, 0, 0, 0);
      v(0, 0, 1, 0, 1, 16'h0000, 16'h2024, 1, 0, 0);
      v(0, 0, 0, 1, 0, 16'h0000, 16'h2025, 0, 0, 0);
      v(0, 0, 0, 0, 1, 16'h0000, 16'h2024, 1, 0, 0);
      v(1, 1, 0, 0, 0, 16'h2050, 16'h2000, 1, 0, 0);
      v(0, 1, 0, 0, 0, 16'h1899, 16'h2000, 1, 0, 1);
      v(0, 1, 0, 0, 0, 16'h1900, 16'h1900, 0, 0, 0);
      v(0, 0, 0, 1, 0, 16'h0000, 16'h1901, 0, 0, 0);
      v(0, 0, 0, 0, 1, 16'h0000, 16'h1900, 0, 0, 0);
      v(0, 0, 0, 0, 1, 16'h0000, 16'h2099, 0, 1, 0);
      v(0, 1, 0, 0, 0, 16'h1F00, 16'h2099, 0, 0, 1);
      v(0, 0, 0, 0, 0, 16'h0000, 16'h2099, 0, 0, 0);

      rst = 1'b1; en_yr = 0; up = 0; down = 0; load = 0; load_val = '0;
      en_b = 0; load_b = 0; val_b = '0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         rst = vecs[i].rst; load = vecs[i].load; en_yr = vecs[i].en;
         up = vecs[i].up; down = vecs[i].down; load_val = vecs[i].val;
         @(posedge clk); #1;
         chk($sformatf("v%0d year", i), year_bcd, vecs[i].exp_year);
         chk($sformatf("v%0d leap", i), 16'(leap_year), 16'(vecs[i].exp_leap));
         chk($sformatf("v%0d wrap", i), 16'(wrap), 16'(vecs[i].exp_wrap));
         chk($sformatf("v%0d load_err", i), 16'(load_err), 16'(vecs[i].exp_err));
      end
      rst = 0; load = 0; en_yr = 0; up = 0; down = 0;

      // Leap sweep on the full-range instance, one en_yr tick per cycle.
      load_b = 1'b1; val_b = 16'h1896;
      @(posedge clk); #1;
      load_b = 1'b0;
      chk("sweep load year", year_b, 16'h1896);
      chk("sweep load leap", 16'(leap_b), 16'(greg_leap(1896)));
      en_b = 1'b1;
      for (int y = 1897; y <= 2404; y++) begin
         @(posedge clk); #1;
         chk($sformatf("sweep %0d year", y), year_b, to_bcd(y));
         chk($sformatf("sweep %0d leap", y), 16'(leap_b), 16'(greg_leap(y)));
         chk($sformatf("sweep %0d wrap", y), 16'(wrap_b), 16'h0);
      end
      en_b = 1'b0;

      // Full-range wrap at 9999 -> 0000, and back down.
      load_b = 1'b1; val_b = 16'h9999;
      @(posedge clk); #1;
      load_b = 1'b0; en_b = 1'b1;
      @(posedge clk); #1;
      en_b = 1'b0;
      chk("full wrap year", year_b, 16'h0000);
      chk("full wrap pulse", 16'(wrap_b), 16'h1);
      chk("full 0000 leap", 16'(leap_b), 16'h1);
      @(posedge clk); #1;
      chk("full wrap clears", 16'(wrap_b), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
